// File: rtl/alu_writeback.sv
// alu_writeback: captures ALU results and sequences register-file writes, flag updates
// and illegal-opcode counting; MUL writes q0 to rd and then q1 to rd+1.
module alu_writeback (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_op,
    input  logic [31:0] in_q0,
    input  logic [31:0] in_q1,
    input  logic [3:0]  in_st,
    input  logic [4:0]  in_rd,
    input  logic        in_setf,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [3:0]  flags,
    output logic [7:0]  err_cnt
);
    typedef enum logic [1:0] {IDLE, WR0, WR1} state_e;
    state_e      state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic [31:0] q0_q, q0_d, q1_q, q1_d;
    logic [3:0]  st_q, st_d, flags_q, flags_d;
    logic [4:0]  rd_q, rd_d, rd1;
    logic        setf_q, setf_d;
    logic [7:0]  err_q, err_d;
    logic        xfer, legal, go, is_mul, last;
    always_comb begin
        is_mul   = op_q == 8'h04;
        rd1      = rd_q + 5'd1;
        in_ready = !(state_q == WR0 && is_mul);
        xfer     = in_valid && in_ready;
        legal    = in_op <= 8'h11;
        go       = xfer && legal && in_op != 8'h00;
        last     = (state_q == WR0 && !is_mul) || state_q == WR1;
        rf_we    = state_q == WR0 ? rd_q != 5'd0 : state_q == WR1 ? rd1 != 5'd0 : 1'b0;
        rf_waddr = state_q == WR0 ? rd_q : state_q == WR1 ? rd1 : 5'd0;
        rf_wdata = state_q == WR0 ? q0_q : state_q == WR1 ? q1_q : 32'd0;
        state_d  = (state_q == WR0 && is_mul) ? WR1 : go ? WR0 : IDLE;
        op_d     = xfer ? in_op : op_q;
        q0_d     = xfer ? in_q0 : q0_q;
        q1_d     = xfer ? in_q1 : q1_q;
        st_d     = xfer ? in_st : st_q;
        rd_d     = xfer ? in_rd : rd_q;
        setf_d   = xfer ? in_setf : setf_q;
        // Flags commit as the final write cycle of a result ends, even when the write itself is suppressed
        flags_d  = (last && setf_q) ? st_q : flags_q;
        err_d    = (xfer && !legal && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
        flags    = flags_q;
        err_cnt  = err_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            q0_q    <= '0;
            q1_q    <= '0;
            st_q    <= '0;
            rd_q    <= '0;
            setf_q  <= 1'b0;
            flags_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            q0_q    <= q0_d;
            q1_q    <= q1_d;
            st_q    <= st_d;
            rd_q    <= rd_d;
            setf_q  <= setf_d;
            flags_q <= flags_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed and random stimulus checked against a queue-of-write-slots
// reference model of the writeback behaviour.
module tb_alu_writeback;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_setf = 1'b0;
    logic        in_ready, rf_we;
    logic [7:0]  in_op = '0, err_cnt;
    logic [31:0] in_q0 = '0, in_q1 = '0, rf_wdata;
    logic [3:0]  in_st = '0, flags;
    logic [4:0]  in_rd = '0, rf_waddr;
    int checks = 0, errors = 0;

    alu_writeback dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_q0(in_q0), .in_q1(in_q1), .in_st(in_st), .in_rd(in_rd),
        .in_setf(in_setf), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flags(flags), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // One entry per expected write cycle, in issue order
    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
        logic        setf;
        logic        mul_first;
        logic [3:0]  st;
    } slot_t;
    slot_t      sq[$];
    logic [3:0] m_flags = '0;
    int         m_err = 0;

    function automatic logic m_ready();
        return sq.size() == 0 || !sq[0].mul_first;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        slot_t s = '{we: 1'b0, addr: 5'd0, data: 32'd0, last: 1'b0, setf: 1'b0, mul_first: 1'b0, st: 4'd0};
        if (sq.size() > 0) s = sq[0];
        chk("rf_we", {31'd0, rf_we}, {31'd0, s.we});
        chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, s.addr});
        chk("rf_wdata", rf_wdata, s.data);
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready()});
        chk("flags", {28'd0, flags}, {28'd0, m_flags});
        chk("err_cnt", {24'd0, err_cnt}, m_err);
    endtask

    task automatic model_edge();
        slot_t s;
        logic [4:0] r1;
        logic xfer = in_valid && m_ready();
        if (sq.size() > 0) begin
            s = sq.pop_front();
            if (s.last && s.setf) m_flags = s.st;
        end
        if (xfer) begin
            if (in_op > 8'h11) m_err = m_err < 255 ? m_err + 1 : 255;
            else if (in_op == 8'h04) begin
                r1 = in_rd + 5'd1;
                sq.push_back('{we: in_rd != 0, addr: in_rd, data: in_q0, last: 1'b0, setf: in_setf, mul_first: 1'b1, st: in_st});
                sq.push_back('{we: r1 != 0, addr: r1, data: in_q1, last: 1'b1, setf: in_setf, mul_first: 1'b0, st: in_st});
            end else if (in_op != 8'h00)
                sq.push_back('{we: in_rd != 0, addr: in_rd, data: in_q0, last: 1'b1, setf: in_setf, mul_first: 1'b0, st: in_st});
        end
    endtask

    // Check current outputs, present new inputs (only while accepting), then advance one edge
    task automatic step(input logic v, input logic [7:0] op, input logic [31:0] q0, input logic [31:0] q1,
                        input logic [3:0] st, input logic [4:0] rd, input logic sf);
        @(negedge clk);
        check_all();
        if (m_ready()) begin
            in_valid = v; in_op = op; in_q0 = q0; in_q1 = q1; in_st = st; in_rd = rd; in_setf = sf;
        end
        @(posedge clk);
        model_edge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 0, 0, 4'h0, 5'd0, 1'b0);
    endtask

    initial begin
        logic [4:0] rd;
        #1;
        chk("reset_we", {31'd0, rf_we}, 32'd0);
        chk("reset_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'h01, 32'h5, 32'h0, 4'h0, 5'd3, 1'b1);
        idle(2);
        step(1'b1, 8'h04, 32'h1, 32'h2, 4'h2, 5'd31, 1'b1);
        idle(3);
        step(1'b1, 8'h02, 32'h11, 32'h0, 4'h8, 5'd1, 1'b0);
        step(1'b1, 8'h05, 32'h22, 32'h0, 4'h1, 5'd2, 1'b1);
        idle(2);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h12, 32'hBAD, 32'h0, 4'hF, 5'd7, 1'b1);
        step(1'b1, 8'h00, 32'h9, 32'h0, 4'hF, 5'd7, 1'b1);
        idle(1);
        chk("err_three", {24'd0, err_cnt}, 32'd3);
        for (int i = 0; i < 256; i++) step(1'b1, 8'(8'h12 + i % 8'hED), 32'h0, 32'h0, 4'h3, 5'd4, 1'b1);
        idle(1);
        chk("err_sat", {24'd0, err_cnt}, 32'hFF);
        step(1'b1, 8'h01, 32'h77, 32'h0, 4'h4, 5'd0, 1'b1);
        idle(2);
        chk("rd0_flags", {28'd0, flags}, 32'h4);
        step(1'b1, 8'h04, 32'hA, 32'hB, 4'h9, 5'd5, 1'b1);
        idle(1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_we", {31'd0, rf_we}, 32'd0);
        chk("async_flags", {28'd0, flags}, 32'd0);
        chk("async_ready", {31'd0, in_ready}, 32'd1);
        sq.delete(); m_flags = '0; m_err = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'h03, 32'h1234, 32'h0, 4'h6, 5'd9, 1'b1);
        idle(2);
        for (int i = 0; i < 1500; i++) begin
            rd = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) ? 5'd31 : 5'd0) : 5'($urandom);
            step($urandom_range(0, 3) != 0, 8'($urandom_range(0, 8'h14)), $urandom, $urandom,
                 4'($urandom), rd, 1'($urandom));
        end
        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
